// File: rtl/uart_byte_rx_pkg.sv
// Shared UART definitions: receiver state encoding and default bit timing.
// Also used by the downstream word/address assembler.
package uart_byte_rx_pkg;

  // 100 MHz system clock / 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_byte_rx_if.sv
// Byte output port of the UART receiver, consumed by the word/address assembler.
interface uart_byte_rx_if;
  // Handshake: valid is a one-cycle strobe with no ready; the consumer must take
  // data_out in the cycle valid is high. frame_err is a separate one-cycle strobe
  // that never coincides with valid. busy is a level: receiver is mid-frame.
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       busy;

  modport master (output data_out, output valid, output frame_err, output busy);
  modport slave  (input  data_out, input  valid, input  frame_err, input  busy);
endinterface

// File: rtl/uart_byte_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
module rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: mid-bit sampling, one-cycle valid / frame_err strobes.
module uart_byte_rx
  import uart_byte_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx,
  uart_byte_rx_if.master out_if,
  output rx_state_t      state_dbg
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  logic rx_s;

  rx_sync #(.RST_VAL(1'b1)) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  rx_state_t   state,   state_nx;
  logic [15:0] cnt,     cnt_nx;
  logic [2:0]  bit_idx, bit_idx_nx;
  logic [7:0]  shift,   shift_nx;
  logic [7:0]  data_q,  data_nx;
  logic        valid_q, valid_nx;
  logic        ferr_q,  ferr_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_idx <= bit_idx_nx;
      shift   <= shift_nx;
      data_q  <= data_nx;
      valid_q <= valid_nx;
      ferr_q  <= ferr_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    bit_idx_nx = bit_idx;
    shift_nx   = shift;
    data_nx    = data_q;
    valid_nx   = 1'b0;
    ferr_nx    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (!rx_s) state_nx = START;
      end
      START: begin
        // A start bit still low at its midpoint is real; otherwise it was a glitch.
        if (cnt == HALF_LAST) begin
          cnt_nx     = '0;
          bit_idx_nx = '0;
          state_nx   = rx_s ? IDLE : DATA;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nx            = '0;
          shift_nx[bit_idx] = rx_s;
          if (bit_idx == 3'd7) state_nx = STOP;
          else                 bit_idx_nx = bit_idx + 3'd1;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nx = '0;
          if (rx_s) begin
            data_nx  = shift;
            valid_nx = 1'b1;
            state_nx = IDLE;
          end else begin
            ferr_nx  = 1'b1;
            state_nx = BREAK;
          end
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      BREAK: begin
        // Wait out a held-low line so it is not mistaken for a new start bit.
        cnt_nx = '0;
        if (rx_s) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign out_if.data_out  = data_q;
  assign out_if.valid     = valid_q;
  assign out_if.frame_err = ferr_q;
  assign out_if.busy      = (state != IDLE);
  assign state_dbg        = state;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx at 16 clocks per bit.
module tb_uart_byte_rx;
  import uart_byte_rx_pkg::*;

  localparam int CPB = 16;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      rx  = 1'b1;
  rx_state_t state_dbg;

  uart_byte_rx_if out_if ();

  uart_byte_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .out_if    (out_if),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset bookkeeping ----------------
  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_at_edge = 1'b1;
  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  // ---------------- scoreboard ----------------
  // exp_q entry: {frame_is_bad, byte}; t_q holds the cycle the start bit was driven
  logic [8:0] exp_q[$];
  int         t_q[$];
  logic [7:0] last_good = 8'h00;
  int         total = 0;
  int         bad = 0;
  int         n_valid = 0;
  int         n_ferr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: unexpected strobe (cycle %0d)", name, cyc);
  endtask

  // Compare process: every negedge the outputs are checked against the model.
  always @(negedge clk) begin
    logic [8:0] e;
    int         t0;
    int         lat;
    if (rst_at_edge) begin
      check("rst_data",  32'(out_if.data_out),  32'h0);
      check("rst_valid", 32'(out_if.valid),     32'h0);
      check("rst_ferr",  32'(out_if.frame_err), 32'h0);
      check("rst_busy",  32'(out_if.busy),      32'h0);
      check("rst_state", 32'(state_dbg),        32'(IDLE));
      last_good = 8'h00;
      exp_q.delete();
      t_q.delete();
    end else if (out_if.valid || out_if.frame_err) begin
      check("strobe_excl", 32'(out_if.valid & out_if.frame_err), 32'h0);
      if (exp_q.size() == 0) begin
        fail_now(out_if.valid ? "spurious_valid" : "spurious_frame_err");
      end else begin
        e   = exp_q.pop_front();
        t0  = t_q.pop_front();
        lat = cyc - t0;
        // stop bit spans 144..160 cycles after the start edge, plus sync/register delay
        check("strobe_window", 32'((lat >= 9*CPB) && (lat <= 10*CPB + 12)), 32'h1);
        check("strobe_kind", 32'(out_if.frame_err), 32'(e[8]));
        if (out_if.valid) begin
          n_valid++;
          check("valid_data", 32'(out_if.data_out), 32'(e[7:0]));
          last_good = e[7:0];
        end else begin
          n_ferr++;
          check("ferr_data_held", 32'(out_if.data_out), 32'(last_good));
        end
      end
    end else begin
      check("data_held", 32'(out_if.data_out), 32'(last_good));
    end
  end

  // ---------------- driver tasks ----------------
  // skew 0: every bit 16 cycles; 1: alternating 15/17; 2: alternating 17/15
  function automatic int bit_len(input int skew, input int j);
    if (skew == 0) return CPB;
    return (((j % 2) == 0) == (skew == 1)) ? CPB - 1 : CPB + 1;
  endfunction

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the stop bit, stop level still driven.
  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int skew);
    logic [9:0] bits;
    bits = {stop_val, b, 1'b0};
    exp_q.push_back({~stop_val, b});
    t_q.push_back(cyc);
    for (int j = 0; j < 10; j++) begin
      rx = bits[j];
      repeat (bit_len(skew, j)) @(posedge clk);
      #1;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int gap;
    int nv0;
    int nf0;
    logic [7:0] rb;
    logic       rbad;

    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(10);

    // single byte
    nv0 = n_valid;
    send_frame(8'hA5, 1'b1, 0);
    idle(4);
    check("a5_data",   32'(out_if.data_out), 32'hA5);
    check("a5_count",  32'(n_valid - nv0),   32'd1);
    check("a5_busy",   32'(out_if.busy),     32'h0);
    check("a5_no_err", 32'(n_ferr),          32'd0);

    // back-to-back frames
    nv0 = n_valid;
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    idle(4);
    check("b2b_count", 32'(n_valid - nv0),   32'd2);
    check("b2b_data",  32'(out_if.data_out), 32'hFF);

    // short low glitch while idle
    nv0 = n_valid;
    nf0 = n_ferr;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    check("glitch_busy_hi", 32'(out_if.busy), 32'h1);
    repeat (10) @(posedge clk);
    #1;
    check("glitch_busy_lo", 32'(out_if.busy), 32'h0);
    idle(10);
    check("glitch_no_pulse", 32'((n_valid - nv0) + (n_ferr - nf0)), 32'd0);

    // framing error, line held low, then recovery
    nf0 = n_ferr;
    send_frame(8'h3C, 1'b0, 0);
    repeat (20) @(posedge clk);
    #1;
    check("brk_busy",   32'(out_if.busy),     32'h1);
    check("brk_data",   32'(out_if.data_out), 32'hFF);
    check("brk_ferr_n", 32'(n_ferr - nf0),    32'd1);
    repeat (20) @(posedge clk);
    #1;
    check("brk_busy_end", 32'(out_if.busy), 32'h1);
    idle(6);
    check("brk_idle", 32'(out_if.busy), 32'h0);
    send_frame(8'h5A, 1'b1, 0);
    idle(4);
    check("after_brk_data", 32'(out_if.data_out), 32'h5A);

    // reset during bit 4 of 8'hC3
    nv0 = n_valid;
    nf0 = n_ferr;
    rx = 1'b0;
    for (int j = 0; j < 5; j++) begin
      repeat (CPB) @(posedge clk);
      #1;
      rx = 8'hC3 >> j;
    end
    repeat (8) @(posedge clk);
    #1;
    check("abort_busy", 32'(out_if.busy), 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rx  = 1'b1;
    check("abort_data0", 32'(out_if.data_out), 32'h00);
    check("abort_busy0", 32'(out_if.busy),     32'h0);
    idle(30);
    check("abort_no_pulse", 32'((n_valid - nv0) + (n_ferr - nf0)), 32'd0);
    send_frame(8'h81, 1'b1, 0);
    idle(4);
    check("after_rst_data", 32'(out_if.data_out), 32'h81);

    // skewed bit periods
    send_frame(8'h96, 1'b1, 1);
    idle(4);
    check("skew1_data", 32'(out_if.data_out), 32'h96);
    send_frame(8'h96, 1'b1, 2);
    idle(4);
    check("skew2_data", 32'(out_if.data_out), 32'h96);

    // randomized traffic
    for (int n = 0; n < 24; n++) begin
      rb   = 8'($urandom_range(0, 255));
      rbad = ($urandom_range(0, 4) == 0);
      send_frame(rb, ~rbad, $urandom_range(0, 2));
      if (rbad) begin
        repeat ($urandom_range(10, 60)) @(posedge clk);
        #1;
        idle(20);
      end else begin
        gap = $urandom_range(0, 3);
        if (gap == 3) begin
          rx = 1'b0;
          repeat ($urandom_range(1, 6)) @(posedge clk);
          #1;
          idle(16);
        end else if (gap > 0) begin
          idle(gap * CPB);
        end
      end
    end

    idle(200);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_busy",        32'(out_if.busy),  32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
